fb_write_ctrl: RTL and testbench

//  Byte-stream command sequencer that owns the framebuffer RAM write port (port A) of vga_mem.

---
 rtl/fb_write_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fb_write_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fb_write_ctrl.sv
// Byte-stream command sequencer driving the framebuffer RAM write port: SET_XY, PIXEL, FILL, CLR_ERR.
// Latency: a pixel write occupies the cycle after its colour byte; rx_ready drops during WRITE and FILL.
module fb_write_ctrl #(
  parameter int RES_X      = 320,
  parameter int RES_Y      = 240,
  parameter int MEM_WIDTH  = 8,
  parameter int MEM_DEPTH  = RES_X * RES_Y,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int X_BITS     = $clog2(RES_X),
  parameter int Y_BITS     = $clog2(RES_Y)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_din,
  output logic                  mem_wen,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_ARG, S_WRITE, S_FILL} state_t;

  localparam logic [7:0] OP_SET_XY  = 8'h01;
  localparam logic [7:0] OP_PIXEL   = 8'h02;
  localparam logic [7:0] OP_FILL    = 8'h03;
  localparam logic [7:0] OP_CLR_ERR = 8'h04;

  state_t                state_q, state_d;
  logic [7:0]            op_q, op_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  xhi_q, xhi_d;
  logic [7:0]            xlo_q, xlo_d;
  logic [X_BITS-1:0]     cur_x_q, cur_x_d;
  logic [Y_BITS-1:0]     cur_y_q, cur_y_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MEM_WIDTH-1:0]  din_q, din_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [X_BITS-1:0]     new_x;
  logic [31:0]           new_x32;
  logic [31:0]           new_y32;

  assign rx_ready = rst_n && ((state_q == S_IDLE) || (state_q == S_ARG));
  assign accept   = rx_valid && rx_ready;
  assign mem_wen  = (state_q == S_WRITE) || (state_q == S_FILL);
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;

  // Full-width product so the bottom-right pixel never aliases to a lower address.
  assign cur_addr = ADDR_WIDTH'(cur_y_q) * ADDR_WIDTH'(RES_X) + ADDR_WIDTH'(cur_x_q);
  assign new_x    = X_BITS'({xhi_q, xlo_q});
  assign new_x32  = 32'(new_x);
  assign new_y32  = 32'(rx_data);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    xhi_d   = xhi_q;
    xlo_d   = xlo_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    addr_d  = addr_q;
    din_d   = din_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = rx_data;
          case (rx_data)
            OP_SET_XY: begin
              cnt_d   = 2'd3;
              state_d = S_ARG;
            end
            OP_PIXEL, OP_FILL: begin
              cnt_d   = 2'd1;
              state_d = S_ARG;
            end
            OP_CLR_ERR: err_d = 1'b0;
            default:    err_d = 1'b1;
          endcase
        end
      end

      S_ARG: begin
        if (accept) begin
          cnt_d = cnt_q - 2'd1;
          case (op_q)
            OP_SET_XY: begin
              if (cnt_q == 2'd3) begin
                xhi_d = rx_data[0];
              end else if (cnt_q == 2'd2) begin
                xlo_d = rx_data;
              end else begin
                if (new_x32 >= 32'(RES_X) || new_y32 >= 32'(RES_Y)) begin
                  err_d = 1'b1;
                end else begin
                  cur_x_d = new_x;
                  cur_y_d = rx_data[Y_BITS-1:0];
                end
                state_d = S_IDLE;
              end
            end
            OP_PIXEL: begin
              addr_d  = cur_addr;
              din_d   = rx_data[MEM_WIDTH-1:0];
              state_d = S_WRITE;
            end
            default: begin
              addr_d  = '0;
              din_d   = rx_data[MEM_WIDTH-1:0];
              state_d = S_FILL;
            end
          endcase
        end
      end

      S_WRITE: begin
        state_d = S_IDLE;
        if (cur_x_q == X_BITS'(RES_X - 1)) begin
          cur_x_d = '0;
          cur_y_d = (cur_y_q == Y_BITS'(RES_Y - 1)) ? '0 : cur_y_q + 1'b1;
        end else begin
          cur_x_d = cur_x_q + 1'b1;
        end
      end

      S_FILL: begin
        if (addr_q == ADDR_WIDTH'(MEM_DEPTH - 1)) begin
          state_d = S_IDLE;
          cur_x_d = '0;
          cur_y_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      xhi_q   <= 1'b0;
      xlo_q   <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      xhi_q   <= xhi_d;
      xlo_q   <= xlo_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Directed bench for fb_write_ctrl: cursor writes, wrap, full fill, error flag, reset abort, slow bytes.
module tb_fb_write_ctrl;

  localparam int DEPTH = 320 * 240;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [16:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_wen;
  logic        busy;
  logic        err;

  int checks;
  int errors;
  int wr_cnt;

  fb_write_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_wen  (mem_wen),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wen) wr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Presents a byte and holds it until the DUT takes it; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pixel(input string tag, input logic [7:0] col, input logic [16:0] exp_addr);
    int c;
    send(8'h02, 0);
    c = wr_cnt;
    send(col, 0);
    chk({tag, "_wen"},  32'(mem_wen),  32'(1));
    chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
    chk({tag, "_din"},  32'(mem_din),  32'(col));
    @(posedge clk);
    #1;
    chk({tag, "_wen_drop"}, 32'(mem_wen), 32'(0));
    chk({tag, "_idle"},     32'(busy),    32'(0));
    chk({tag, "_count"},    32'(wr_cnt - c), 32'(1));
  endtask

  initial begin
    int n;
    int bad;
    int c;

    checks   = 0;
    errors   = 0;
    wr_cnt   = 0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 32'(0));
    chk("rst_wen",   32'(mem_wen),  32'(0));
    chk("rst_busy",  32'(busy),     32'(0));
    chk("rst_err",   32'(err),      32'(0));
    chk("rst_addr",  32'(mem_addr), 32'(0));
    chk("rst_din",   32'(mem_din),  32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rx_ready), 32'(1));

    // Cursor to (10,5): 5*320+10 = 1610, then advance to 1611
    send(8'h01, 0); send(8'h00, 0); send(8'h0A, 0); send(8'h05, 0);
    chk("setxy_err", 32'(err), 32'(0));
    pixel("px1610", 8'h30, 17'd1610);
    pixel("px1611", 8'h31, 17'd1611);

    // Bottom-right pixel, then wrap to origin
    send(8'h01, 0); send(8'h01, 0); send(8'h3F, 0); send(8'hEF, 0);
    chk("setxy_corner_err", 32'(err), 32'(0));
    pixel("px_last", 8'h0C, 17'd76799);
    pixel("px_wrap", 8'h03, 17'd0);
    pixel("px_after_wrap", 8'h07, 17'd1);

    // Full-screen fill
    send(8'h03, 0);
    send(8'h15, 0);
    n = 0;
    bad = 0;
    while (mem_wen && n < DEPTH + 100) begin
      if (mem_addr != 17'(n) || mem_din != 8'h15 || rx_ready || !busy) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("fill_len",   32'(n),   32'(DEPTH));
    chk("fill_bad",   32'(bad), 32'(0));
    chk("fill_busy",  32'(busy), 32'(0));
    chk("fill_ready", 32'(rx_ready), 32'(1));
    chk("fill_hold_addr", 32'(mem_addr), 32'(DEPTH - 1));
    pixel("px_post_fill", 8'h22, 17'd0);

    // Out-of-range x=320 sets err and leaves cursor at (1,0)
    send(8'h01, 0); send(8'h01, 0); send(8'h40, 0); send(8'h00, 0);
    chk("badxy_err", 32'(err), 32'(1));
    pixel("px_badxy", 8'h44, 17'd1);
    chk("err_sticky_px", 32'(err), 32'(1));
    send(8'h7F, 0);
    chk("badop_err",  32'(err),  32'(1));
    chk("badop_idle", 32'(busy), 32'(0));
    send(8'h04, 0);
    chk("clr_err", 32'(err), 32'(0));
    // y=240 is also out of range
    send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'hF0, 0);
    chk("bady_err", 32'(err), 32'(1));
    send(8'h04, 0);
    chk("clr_err2", 32'(err), 32'(0));

    // Reset in the middle of a fill
    send(8'h03, 0);
    send(8'h15, 0);
    n = 0;
    while (mem_addr != 17'd1000 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("fill_reach_1000", 32'(n < 2000), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("abort_wen",   32'(mem_wen),  32'(0));
    chk("abort_busy",  32'(busy),     32'(0));
    chk("abort_ready", 32'(rx_ready), 32'(0));
    chk("abort_addr",  32'(mem_addr), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    pixel("px_after_abort", 8'h5A, 17'd0);

    // Slow bytes: long gaps inside SET_XY
    c = wr_cnt;
    send(8'h01, 0);
    send(8'h00, 50);
    chk("slow_busy", 32'(busy), 32'(1));
    send(8'h0A, 50);
    repeat (20) @(negedge clk);
    chk("slow_ready", 32'(rx_ready), 32'(1));
    send(8'h05, 50);
    chk("slow_writes", 32'(wr_cnt - c), 32'(0));
    chk("slow_err",    32'(err),  32'(0));
    chk("slow_idle",   32'(busy), 32'(0));
    pixel("px_slow", 8'h66, 17'd1610);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
